// File: rtl/local_mem_avmm_responder_if.sv
// Avalon-MM local-memory bus between an AFU master and the bank responder.
// The master modport drives commands, the slave modport returns wait/read data.
interface local_mem_avmm_responder_if #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0]      avs_address;
  logic                       avs_write;
  logic                       avs_read;
  logic [DATA_WIDTH-1:0]      avs_writedata;
  logic [DATA_WIDTH/8-1:0]    avs_byteenable;
  logic [BURST_CNT_WIDTH-1:0] avs_burstcount;
  logic                       avs_waitrequest;
  logic [DATA_WIDTH-1:0]      avs_readdata;
  logic                       avs_readdatavalid;

  modport master (
    output avs_address, avs_write, avs_read, avs_writedata, avs_byteenable, avs_burstcount,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_write, avs_read, avs_writedata, avs_byteenable, avs_burstcount,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/local_mem_avmm_responder.sv
// Avalon-MM slave modelling one local-memory bank: burst writes with byte enables, queued in-order read bursts.
// Define LOCAL_MEM_RESP_BACKPRESSURE_EN to add LFSR-driven random waitrequest.
module local_mem_avmm_responder #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int DEPTH_LOG2      = 12,
  parameter int READ_LATENCY    = 3,
  parameter int RD_CMD_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          SoftReset,
  local_mem_avmm_responder_if.slave     avs,
  output logic                          err_protocol
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = (RD_CMD_DEPTH > 1) ? $clog2(RD_CMD_DEPTH) : 1;
  localparam int CNT_W = $clog2(RD_CMD_DEPTH + 1);
  localparam int PIPE  = READ_LATENCY - 1;
  localparam logic [BURST_CNT_WIDTH-1:0] ONE_BC    = BURST_CNT_WIDTH'(1);
  localparam logic [CNT_W-1:0]           FIFO_FULL = CNT_W'(RD_CMD_DEPTH);
  localparam logic [PTR_W-1:0]           PTR_LAST  = PTR_W'(RD_CMD_DEPTH - 1);

  logic [DATA_WIDTH-1:0]      r_mem       [DEPTH];
  logic [DEPTH_LOG2-1:0]      r_fifo_base [RD_CMD_DEPTH];
  logic [BURST_CNT_WIDTH-1:0] r_fifo_len  [RD_CMD_DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]           r_fifo_cnt;
  logic                       r_wait_init;
  logic                       r_wr_active;
  logic [DEPTH_LOG2-1:0]      r_wr_base;
  logic [BURST_CNT_WIDTH-1:0] r_wr_beat, r_wr_len;
  logic [BURST_CNT_WIDTH-1:0] r_rd_beat;
  logic [PIPE-1:0]            r_pipe_vld;
  logic [DATA_WIDTH-1:0]      r_pipe_data [PIPE];
  logic                       r_err;

  logic [DEPTH_LOG2-1:0]      w_addr_idx, w_wr_idx, w_rd_idx;
  logic [BURST_CNT_WIDTH-1:0] w_len;
  logic w_fifo_full, w_fifo_empty, w_rd_req, w_bp, w_wait;
  logic w_wr_acc, w_rd_acc, w_rd_issue, w_rd_last, w_pop, w_err;
  logic w_unused;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef LOCAL_MEM_RESP_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) r_lfsr <= 16'hACE1;
    else           r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_bp = (r_lfsr[1:0] == 2'b00);
`else
  assign w_bp = 1'b0;
`endif

  assign w_unused     = &{1'b0, avs.avs_address[ADDR_WIDTH-1:DEPTH_LOG2]};
  assign w_addr_idx   = avs.avs_address[DEPTH_LOG2-1:0];
  assign w_len        = (avs.avs_burstcount == '0) ? ONE_BC : avs.avs_burstcount;
  assign w_fifo_full  = (r_fifo_cnt == FIFO_FULL);
  assign w_fifo_empty = (r_fifo_cnt == '0);
  // Reads lose to a simultaneous write and are ignored while a write burst is open.
  assign w_rd_req     = avs.avs_read && !avs.avs_write && !r_wr_active;
  assign w_wait       = r_wait_init | (w_fifo_full & w_rd_req) | w_bp;
  assign w_wr_acc     = avs.avs_write && !w_wait;
  assign w_rd_acc     = w_rd_req && !w_wait;
  assign w_wr_idx     = r_wr_active ? r_wr_base + DEPTH_LOG2'(r_wr_beat) : w_addr_idx;

  assign w_err = (avs.avs_read || avs.avs_write) && !w_wait &&
                 ((avs.avs_read && avs.avs_write) || (avs.avs_read && r_wr_active) ||
                  (((avs.avs_write && !r_wr_active) || w_rd_acc) && avs.avs_burstcount == '0));

  // The head command stays in the FIFO while it streams; it is popped on its last beat.
  assign w_rd_issue = !w_fifo_empty;
  assign w_rd_idx   = r_fifo_base[r_rd_ptr] + DEPTH_LOG2'(r_rd_beat);
  assign w_rd_last  = ((r_rd_beat + ONE_BC) == r_fifo_len[r_rd_ptr]);
  assign w_pop      = w_rd_issue && w_rd_last;

  assign avs.avs_waitrequest   = w_wait;
  assign avs.avs_readdatavalid = r_pipe_vld[PIPE-1];
  assign avs.avs_readdata      = r_pipe_data[PIPE-1];
  assign err_protocol          = r_err;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (w_wr_acc && avs.avs_byteenable[i])
        r_mem[w_wr_idx][8*i +: 8] <= avs.avs_writedata[8*i +: 8];
    end
    if (w_rd_acc) begin
      r_fifo_base[r_wr_ptr] <= w_addr_idx;
      r_fifo_len[r_wr_ptr]  <= w_len;
    end
  end

  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      r_wait_init <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_wr_active <= 1'b0;
      r_wr_base   <= '0;
      r_wr_beat   <= '0;
      r_wr_len    <= '0;
      r_rd_beat   <= '0;
      r_pipe_vld  <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < PIPE; i++) r_pipe_data[i] <= '0;
    end else begin
      r_wait_init <= 1'b0;
      if (w_err) r_err <= 1'b1;

      if (w_wr_acc) begin
        if (!r_wr_active) begin
          if (w_len != ONE_BC) begin
            r_wr_active <= 1'b1;
            r_wr_base   <= w_addr_idx;
            r_wr_len    <= w_len;
            r_wr_beat   <= ONE_BC;
          end
        end else begin
          if ((r_wr_beat + ONE_BC) == r_wr_len) r_wr_active <= 1'b0;
          r_wr_beat <= r_wr_beat + ONE_BC;
        end
      end

      if (w_rd_acc) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_rd_acc && !w_pop)      r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
      else if (!w_rd_acc && w_pop) r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);

      if (w_rd_issue) r_rd_beat <= w_rd_last ? '0 : r_rd_beat + ONE_BC;

      r_pipe_vld[0] <= w_rd_issue;
      if (w_rd_issue) r_pipe_data[0] <= r_mem[w_rd_idx];
      for (int i = 1; i < PIPE; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end
endmodule

// File: tb/tb_local_mem_avmm_responder.sv
// Directed bench for local_mem_avmm_responder with a small bank (64 words x 64 bits).
// Captures every readdatavalid beat with its cycle number and checks against hand-computed values.
module tb_local_mem_avmm_responder;
  localparam int AW = 16, DW = 64, BCW = 7, DL = 6, RL = 3, RCD = 4;

  logic clk = 1'b0;
  logic SoftReset;
  logic err_protocol;
  always #5 clk = ~clk;

  local_mem_avmm_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW)) avs();

  local_mem_avmm_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW),
    .DEPTH_LOG2(DL), .READ_LATENCY(RL), .RD_CMD_DEPTH(RCD)
  ) dut (
    .clk(clk), .SoftReset(SoftReset), .avs(avs), .err_protocol(err_protocol)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] rq_data[$];
  int          rq_cyc[$];
  always @(negedge clk) begin
    if (avs.avs_readdatavalid === 1'b1) begin
      rq_data.push_back(avs.avs_readdata);
      rq_cyc.push_back(cyc);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    rq_data.delete();
    rq_cyc.delete();
  endtask

  task automatic bus_req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                         input logic [63:0] wd, input logic [7:0] be,
                         input logic [BCW-1:0] bc, output int acc);
    int n;
    avs.avs_read = rd;  avs.avs_write = wr;  avs.avs_address = addr;
    avs.avs_writedata = wd;  avs.avs_byteenable = be;  avs.avs_burstcount = bc;
    acc = -1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (avs.avs_waitrequest === 1'b0) break;
      @(posedge clk); #1;
    end
    if (n == 100) check("req_timeout", {63'd0, avs.avs_waitrequest}, 64'd0);
    acc = cyc;
    @(posedge clk); #1;
    avs.avs_read = 1'b0;
    avs.avs_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input string tag, input int n);
    for (int i = 0; i < 300 && rq_data.size() < n; i++) @(posedge clk);
    #1;
    idle(3);
    check({tag, "_count"}, 64'(rq_data.size()), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] D_A5 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] D_CC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] D_AA = 64'hAAAA_0000_AAAA_0009;
  localparam logic [63:0] D_BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] D_12 = 64'h1212_1212_1212_1212;

  int acc, accw;
  int acc_q[5];
  logic [63:0] burst_wd[4];
  logic [7:0]  burst_be[4];
  logic [63:0] burst_exp[4];

  initial begin
    SoftReset = 1'b1;
    avs.avs_read = 1'b0;  avs.avs_write = 1'b0;  avs.avs_address = '0;
    avs.avs_writedata = '0;  avs.avs_byteenable = '0;  avs.avs_burstcount = '0;

    // reset values and the one-cycle post-reset stall
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitreq", {63'd0, avs.avs_waitrequest}, 64'd1);
    check("rst_rdvalid", {63'd0, avs.avs_readdatavalid}, 64'd0);
    check("rst_rddata", avs.avs_readdata, 64'd0);
    check("rst_err", {63'd0, err_protocol}, 64'd0);
    @(posedge clk); #1;
    SoftReset = 1'b0;
    @(negedge clk);
    check("post_rst_wait_hi", {63'd0, avs.avs_waitrequest}, 64'd1);
    @(posedge clk); @(negedge clk);
    check("post_rst_wait_lo", {63'd0, avs.avs_waitrequest}, 64'd0);
    @(posedge clk); #1;

    // single word write then read
    bus_req(1'b0, 1'b1, 16'd5, D_A5, 8'hFF, 7'd1, accw);
    bus_req(1'b1, 1'b0, 16'd5, 64'd0, 8'h00, 7'd1, acc);
    wait_beats("single", 1);
    check("single_data", rq_data[0], D_A5);
    check("single_latency", 64'(rq_cyc[0]), 64'(acc + RL));
    check("single_err", {63'd0, err_protocol}, 64'd0);
    clear_q();

    // 4-beat write wrapping past the top, byte mask on beat 1
    bus_req(1'b0, 1'b1, 16'd63, D_CC, 8'hFF, 7'd1, accw);
    burst_wd  = '{64'h1010_1010_1010_1010, 64'h2121_2121_2121_2121,
                  64'h3232_3232_3232_3232, 64'h4343_4343_4343_4343};
    burst_be  = '{8'hFF, 8'h0F, 8'hFF, 8'hFF};
    burst_exp = '{64'h1010_1010_1010_1010, 64'hCCCC_CCCC_2121_2121,
                  64'h3232_3232_3232_3232, 64'h4343_4343_4343_4343};
    for (int k = 0; k < 4; k++)
      bus_req(1'b0, 1'b1, 16'd62, burst_wd[k], burst_be[k], 7'd4, accw);
    bus_req(1'b1, 1'b0, 16'd62, 64'd0, 8'h00, 7'd4, acc);
    wait_beats("burst", 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("burst_data%0d", k), rq_data[k], burst_exp[k]);
      check($sformatf("burst_cyc%0d", k), 64'(rq_cyc[k]), 64'(acc + RL + k));
    end
    clear_q();

    // fill words 20..59, then RCD+1 back-to-back 8-beat reads
    for (int j = 0; j < 40; j++)
      bus_req(1'b0, 1'b1, 16'd20, 64'hD000_0000_0000_0000 | 64'(j), 8'hFF, 7'd40, accw);
    for (int m = 0; m < 4; m++)
      bus_req(1'b1, 1'b0, 16'(20 + 8*m), 64'd0, 8'h00, 7'd8, acc_q[m]);
    avs.avs_read = 1'b1;  avs.avs_address = 16'd52;  avs.avs_burstcount = 7'd8;
    @(negedge clk);
    check("qfill_stall", {63'd0, avs.avs_waitrequest}, 64'd1);
    bus_req(1'b1, 1'b0, 16'd52, 64'd0, 8'h00, 7'd8, acc_q[4]);
    check("qfill_accept_cyc", 64'(acc_q[4]), 64'(acc_q[0] + 9));
    wait_beats("qfill", 40);
    for (int j = 0; j < 40; j++) begin
      check($sformatf("qfill_data%0d", j), rq_data[j], 64'hD000_0000_0000_0000 | 64'(j));
      check($sformatf("qfill_cyc%0d", j), 64'(rq_cyc[j]), 64'(acc_q[0] + RL + j));
    end
    clear_q();

    // write lands before the beat's RAM read -> new data
    bus_req(1'b0, 1'b1, 16'd9, 64'h0909_0909_0909_0909, 8'hFF, 7'd1, accw);
    bus_req(1'b1, 1'b0, 16'd7, 64'd0, 8'h00, 7'd4, acc);
    bus_req(1'b0, 1'b1, 16'd9, D_AA, 8'hFF, 7'd1, accw);
    check("wdr_write_cyc", 64'(accw), 64'(acc + 1));
    wait_beats("wdr_new", 4);
    check("wdr_new_data", rq_data[2], D_AA);
    clear_q();

    // write in the same cycle as the beat's RAM read -> old data
    bus_req(1'b1, 1'b0, 16'd9, 64'd0, 8'h00, 7'd1, acc);
    bus_req(1'b0, 1'b1, 16'd9, D_BB, 8'hFF, 7'd1, accw);
    wait_beats("wdr_old", 1);
    check("wdr_old_data", rq_data[0], D_AA);
    clear_q();
    bus_req(1'b1, 1'b0, 16'd9, 64'd0, 8'h00, 7'd1, acc);
    wait_beats("wdr_after", 1);
    check("wdr_after_data", rq_data[0], D_BB);
    clear_q();

    // burstcount 0 read behaves as one beat and flags an error
    check("bc0_err_before", {63'd0, err_protocol}, 64'd0);
    bus_req(1'b1, 1'b0, 16'd5, 64'd0, 8'h00, 7'd0, acc);
    wait_beats("bc0", 1);
    check("bc0_data", rq_data[0], D_A5);
    check("bc0_err", {63'd0, err_protocol}, 64'd1);
    clear_q();

    // reset in the middle of an 8-beat read burst
    bus_req(1'b1, 1'b0, 16'd20, 64'd0, 8'h00, 7'd8, acc);
    idle(3);
    SoftReset = 1'b1;
    #1;
    check("midrst_rdvalid", {63'd0, avs.avs_readdatavalid}, 64'd0);
    check("midrst_waitreq", {63'd0, avs.avs_waitrequest}, 64'd1);
    clear_q();
    repeat (2) @(posedge clk);
    #1;
    SoftReset = 1'b0;
    @(negedge clk);
    check("midrst_wait_hi", {63'd0, avs.avs_waitrequest}, 64'd1);
    @(posedge clk); @(negedge clk);
    check("midrst_wait_lo", {63'd0, avs.avs_waitrequest}, 64'd0);
    check("midrst_err_clr", {63'd0, err_protocol}, 64'd0);
    @(posedge clk); #1;
    idle(12);
    check("midrst_no_beats", 64'(rq_data.size()), 64'd0);
    bus_req(1'b1, 1'b0, 16'd5, 64'd0, 8'h00, 7'd1, acc);
    wait_beats("midrst_fresh", 1);
    check("midrst_fresh_data", rq_data[0], D_A5);
    check("midrst_fresh_cyc", 64'(rq_cyc[0]), 64'(acc + RL));
    clear_q();

    // read and write together: write wins, read dropped, error flagged
    bus_req(1'b1, 1'b1, 16'd12, D_12, 8'hFF, 7'd1, accw);
    idle(8);
    check("rw_no_beats", 64'(rq_data.size()), 64'd0);
    check("rw_err", {63'd0, err_protocol}, 64'd1);
    bus_req(1'b1, 1'b0, 16'd12, 64'd0, 8'h00, 7'd1, acc);
    wait_beats("rw_read", 1);
    check("rw_write_data", rq_data[0], D_12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/local_mem_avmm_responder.md
# local_mem_avmm_responder

Avalon-MM slave that terminates the local-memory master port driven by an AFU (`avs_*` signals) and models one local-memory bank with a synchronous RAM. It accepts single and burst reads and writes, applies per-byte enables, and returns read bursts in order with a fixed latency. It is used as the bank model in AFU simulation benches and as an on-chip scratch bank in builds without EMIF.

## Interface
**Parameters**
- `ADDR_WIDTH`, default 27: word address width. One word is one `DATA_WIDTH` line.
- `DATA_WIDTH`, default 512: data width in bits. Must be a multiple of 8.
- `BURST_CNT_WIDTH`, default 7: burstcount width.
- `DEPTH_LOG2`, default 12: the RAM holds 2^DEPTH_LOG2 words.
- `READ_LATENCY`, default 3: cycles from read acceptance to the first `readdatavalid`. Must be ≥2.
- `RD_CMD_DEPTH`, default 4: number of outstanding read commands that can be queued.

**Ports**
- `clk` in 1: the single clock.
- `SoftReset` in 1: reset. Asynchronous assert, active-high.
- `avs_address` in ADDR_WIDTH: word address. Only the first beat of a burst is sampled.
- `avs_write` in 1: write request.
- `avs_read` in 1: read request.
- `avs_writedata` in DATA_WIDTH: write data.
- `avs_byteenable` in DATA_WIDTH/8: per-byte write enable.
- `avs_burstcount` in BURST_CNT_WIDTH: number of beats, sampled on the first beat.
- `avs_waitrequest` out 1: stall. A request is accepted in any cycle where (read|write) && !waitrequest.
- `avs_readdata` out DATA_WIDTH: read data.
- `avs_readdatavalid` out 1: read beat valid.
- `err_protocol` out 1: sticky error flag, cleared only by reset.

## Operation
**Addressing**
- RAM index = `avs_address[DEPTH_LOG2-1:0]`, i.e. addresses wrap modulo the depth.
- Beat k of a burst uses index base+k modulo 2^DEPTH_LOG2.

**Writes**
- The first accepted beat latches the base address and burstcount. A beat counter starts at 1.
- Each accepted beat writes the enabled bytes at base+counter-1. Bytes with enable 0 are unchanged.
- The burst ends when the counter reaches burstcount. The next accepted request then starts a new command.

**Reads**
- An accepted read pushes {base, count} into the command FIFO (depth RD_CMD_DEPTH).
- The read engine pops one command at a time. It issues one RAM read per cycle for each beat.
- Read data passes through a pipeline of READ_LATENCY-1 stages, then drives `avs_readdata`/`avs_readdatavalid`.
- Bursts are returned back-to-back and strictly in acceptance order.

**waitrequest**
- Asserted while in reset.
- Asserted for one cycle after reset deasserts.
- Asserted when the FIFO is full and `avs_read` is high.
- Otherwise deasserted.
- Writes are never stalled by pending reads.

**Protocol errors** (each sets `err_protocol`)
- burstcount == 0: treated as 1.
- `avs_read` and `avs_write` both high: treated as a write, and the read is dropped.
- `avs_read` asserted mid write burst: ignored until the burst completes.

**Reset**
- Outputs reset to: `avs_waitrequest`=1, `avs_readdatavalid`=0, `avs_readdata`=0, `err_protocol`=0.
- Reset flushes the FIFO, the pipeline, and any partial write burst.
- A read burst in flight is abandoned, and no further `readdatavalid` is produced.
- RAM contents are not reset.

## Timing
- **Read latency:** a read accepted at cycle T with the FIFO and engine idle gives beat 0 valid at T+READ_LATENCY and beat k at T+READ_LATENCY+k.
- **Queued reads:** a queued read's first beat follows the previous burst's last beat with zero idle cycles.
- **Read-after-write:** a write beat accepted at cycle W is visible to any beat whose RAM read occurs at W+1 or later. RAM read for a beat occurs at its valid cycle minus (READ_LATENCY-1).
- **Same-cycle write and RAM read of the same index:** the read returns old data.
- **FIFO full:** `avs_waitrequest` deasserts the cycle after a pop frees an entry (registered full flag).
- **Throughput:** one write beat per cycle sustained, one read beat per cycle sustained.

## Configuration
- `LOCAL_MEM_RESP_BACKPRESSURE_EN` defined:
  - A 16-bit LFSR (seed 16'hACE1, reset to seed) additionally asserts `avs_waitrequest` whenever LFSR[1:0]==2'b00.
  - This applies to both reads and writes, including mid-burst.
  - The read return schedule is unchanged once a command is accepted.
- Macro undefined: waitrequest only as described under Operation. No LFSR logic is present.

## Test plan
- **Single word:** write addr 5, data 0x…A5 (all bytes enabled); read addr 5 → readdatavalid exactly READ_LATENCY cycles after acceptance with 0x…A5; err_protocol=0.
- **Write burst with byte mask:** 4-beat write at addr 2^DEPTH_LOG2-2, byteenable 0x0F only on beat 1; read 4 beats from the same address → indices wrap to 0,1; beat 1 holds the new low 4 bytes and the old remaining bytes.
- **Queue fill:** issue RD_CMD_DEPTH+1 back-to-back 8-beat reads → waitrequest high on the last request until the first pop; all 40 beats returned contiguous and in order.
- **Write during reads:** write addr 9 while a read burst covering addr 9 is outstanding, with the beat's RAM read after the write → new data returned; with the RAM read before the write → old data returned.
- **Protocol errors:** burstcount=0 read → one beat and err_protocol=1; read+write asserted together → write committed, no readdatavalid.
- **Reset mid-burst:** SoftReset asserted mid read burst → readdatavalid 0 the same cycle (async); after release, waitrequest low after 1 cycle and a fresh read succeeds.
